// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage bus access unit.
// Takes one load or store per M-stage instruction and runs it on a single-outstanding
// req/ack bus. The pipeline is stalled until the bus completes. The load result is
// registered into ReadDataM for capture into the writeback stage.
// Optional feature: define MEM_TIMEOUT_EN to add a bus watchdog. The watchdog aborts
// an unacknowledged access after TIMEOUT BUS cycles and pulses MemErrM.
module mem_access_unit #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic            ByteM,
    input  logic [SIZE-1:0] ALUOutM,
    input  logic [SIZE-1:0] WriteDataM,
    output logic            StallM,
    output logic [SIZE-1:0] ReadDataM,
    output logic            MemErrM,
    output logic            BusReq,
    output logic            BusWe,
    output logic [SIZE-1:0] BusAddr,
    output logic [3:0]      BusBE,
    output logic [SIZE-1:0] BusWData,
    input  logic            BusAck,
    input  logic [SIZE-1:0] BusRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        is_byte;   // access in flight is a byte access
    logic [1:0]  lane;      // byte lane of the access in flight
    logic        pending;
    logic [7:0]  lane_data;
    logic [SIZE-1:0] load_data;

    assign pending = MemReadM | MemWriteM;

    // The instruction may only advance once its access has reached DONE.
    assign StallM = pending & (state != DONE);

    // Extract the addressed byte lane for byte loads, or pass the word through.
    always_comb begin
        lane_data = BusRData[{lane, 3'b000} +: 8];
        load_data = is_byte ? {{(SIZE-8){1'b0}}, lane_data} : BusRData;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          mem_err;
    assign MemErrM = mem_err;
`else
    assign MemErrM = 1'b0;
`endif

    // Access FSM: latches the bus fields on IDLE->BUS, waits for ack, then spends one DONE cycle.
    always_ff @(posedge CLK) begin
        // NOTE: every register here uses <= so that all of them sample the pre-edge values.
        if (RST) begin
            state     <= IDLE;
            BusReq    <= 1'b0;
            BusWe     <= 1'b0;
            BusAddr   <= '0;
            BusBE     <= '0;
            BusWData  <= '0;
            ReadDataM <= '0;
            is_byte   <= 1'b0;
            lane      <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state    <= BUS;
                        BusReq   <= 1'b1;
                        // A load/store conflict resolves to a store.
                        BusWe    <= MemWriteM;
                        BusAddr  <= {ALUOutM[SIZE-1:2], 2'b00};
                        is_byte  <= ByteM;
                        lane     <= ALUOutM[1:0];
                        if (ByteM) begin
                            BusBE    <= 4'b0001 << ALUOutM[1:0];
                            BusWData <= {(SIZE/8){WriteDataM[7:0]}};
                        end else begin
                            BusBE    <= 4'b1111;
                            BusWData <= WriteDataM;
                        end
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                BUS: begin
                    // An ack in the expiry cycle takes priority over the watchdog.
                    if (BusAck) begin
                        state  <= DONE;
                        BusReq <= 1'b0;
                        if (!BusWe) begin
                            ReadDataM <= load_data;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        BusReq  <= 1'b0;
                        mem_err <= 1'b1;
                        if (!BusWe) begin
                            ReadDataM <= '1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    mem_err <= 1'b0;
`endif
                end
                // NOTE: the unused encoding recovers to IDLE instead of locking up.
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Every access pushes an expected bus
// transaction into a scoreboard. That entry is popped and compared when the DUT
// raises BusReq. The bench also checks the final stall count and the load result.
// Build with MEM_TIMEOUT_EN defined to exercise the watchdog.
module tb_mem_access_unit;

    localparam int SIZE    = 32;
    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 60;

    logic            CLK = 1'b0;
    logic            RST;
    logic            MemReadM, MemWriteM, ByteM;
    logic [SIZE-1:0] ALUOutM, WriteDataM;
    logic            StallM;
    logic [SIZE-1:0] ReadDataM;
    logic            MemErrM;
    logic            BusReq, BusWe;
    logic [SIZE-1:0] BusAddr;
    logic [3:0]      BusBE;
    logic [SIZE-1:0] BusWData;
    logic            BusAck;
    logic [SIZE-1:0] BusRData;

    mem_access_unit #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MemErrM(MemErrM),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBE(BusBE),
        .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Run one memory instruction. The slave acks after 'waits' no-ack BUS cycles.
    task automatic do_access(input string name, input logic rd, input logic wr, input logic bt,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits);
        exp_t       e;
        exp_t       got;
        logic [7:0] sel;
        int         stalls = 0;
        int         left   = waits;
        int         cyc    = 0;
        bit         seen   = 0;
        bit         done   = 0;
        bit         tmo    = 0;
`ifdef MEM_TIMEOUT_EN
        tmo = (waits >= TIMEOUT);
`endif
        e.we    = wr;
        e.addr  = {addr[31:2], 2'b00};
        e.be    = 4'b1111;
        e.wdata = wdata;
        sel     = rdata[7:0];
        if (bt) begin
            case (addr[1:0])
                2'd0: begin e.be = 4'b0001; sel = rdata[7:0];   end
                2'd1: begin e.be = 4'b0010; sel = rdata[15:8];  end
                2'd2: begin e.be = 4'b0100; sel = rdata[23:16]; end
                default: begin e.be = 4'b1000; sel = rdata[31:24]; end
            endcase
            e.wdata = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
        end
        if (!wr) begin
            if (tmo)     model_rd = 32'hFFFF_FFFF;
            else if (bt) model_rd = {24'h0, sel};
            else         model_rd = rdata;
        end
        e.rdata  = model_rd;
        e.stalls = tmo ? (1 + TIMEOUT) : (waits + 2);
        e.err    = tmo;
        sb_q.push_back(e);

        MemReadM   = rd;
        MemWriteM  = wr;
        ByteM      = bt;
        ALUOutM    = addr;
        WriteDataM = wdata;
        #1;
        while (!done && cyc < BUDGET) begin
            if (StallM) stalls++;
            if (BusReq) begin
                if (!seen) begin
                    got  = sb_q.pop_front();
                    seen = 1;
                end
                check({name, "_we"},    BusWe,    got.we);
                check({name, "_addr"},  BusAddr,  got.addr);
                check({name, "_be"},    BusBE,    got.be);
                check({name, "_wdata"}, BusWData, got.wdata);
                BusRData = rdata;
                if (left == 0) BusAck = 1'b1;
                else           left--;
            end else if (!StallM) begin
                done = 1;
            end
            if (!done) begin
                tick();
                BusAck = 1'b0;
                cyc++;
            end
        end
        check({name, "_finished"}, done, 1'b1);
        check({name, "_req_seen"}, seen, 1'b1);
        if (seen) begin
            check({name, "_stalls"}, 32'(stalls), 32'(got.stalls));
            check({name, "_rdata"},  ReadDataM,   got.rdata);
            check({name, "_err"},    MemErrM,     got.err);
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        // The instruction leaves M; the next cycle is IDLE with the bus quiet.
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        tick();
        check({name, "_idle_req"},   BusReq,  1'b0);
        check({name, "_idle_stall"}, StallM,  1'b0);
        check({name, "_idle_err"},   MemErrM, 1'b0);
    endtask

    initial begin
        int hi;
        RST = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
        ALUOutM = '0; WriteDataM = '0; BusAck = 1'b0; BusRData = '0;
        tick();
        tick();
        check("rst_req",   BusReq,    1'b0);
        check("rst_we",    BusWe,     1'b0);
        check("rst_addr",  BusAddr,   32'h0);
        check("rst_be",    BusBE,     4'h0);
        check("rst_wdata", BusWData,  32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_err",   MemErrM,   1'b0);
        check("rst_stall", StallM,    1'b0);
        RST = 1'b0;

        // Non-memory instructions: no stall, no bus activity, even with a stray ack.
        ALUOutM = 32'h0000_0104;
        BusAck  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nomem_stall", StallM, 1'b0);
            check("nomem_req",   BusReq, 1'b0);
        end
        BusAck = 1'b0;

        do_access("wload",  1, 0, 0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 0);
        do_access("bload",  1, 0, 1, 32'h0000_0103, 32'h0,         32'hA1B2_C3D4, 3);
        do_access("bstore", 0, 1, 1, 32'h0000_0201, 32'h0000_0055, 32'h0,         0);
        do_access("rw0",    1, 1, 0, 32'h0000_0010, 32'h1234_5678, 32'h0,         2);
        do_access("rw1",    1, 1, 0, 32'h0000_0014, 32'h9ABC_DEF0, 32'h0,         2);
        for (int i = 0; i < 4; i++)
            do_access($sformatf("lane%0d", i), 1, 0, 1, 32'h40 + 32'(i), 32'h0, 32'h1122_3344, i);
        do_access("misal",  1, 0, 0, 32'h0000_0107, 32'h0,         32'h5A5A_0F0F, 1);
        do_access("bst3",   0, 1, 1, 32'h0000_0083, 32'hFFFF_FF9C, 32'h0,         1);

        // Reset in the second BUS cycle abandons the load; a late ack is ignored.
        MemReadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; ALUOutM = 32'h300;
        tick();
        tick();
        check("rstbus_req_before", BusReq, 1'b1);
        RST = 1'b1;
        MemReadM = 1'b0;
        tick();
        RST = 1'b0;
        model_rd = '0;
        check("rstbus_req",   BusReq,    1'b0);
        check("rstbus_rdata", ReadDataM, model_rd);
        check("rstbus_addr",  BusAddr,   32'h0);
        check("rstbus_be",    BusBE,     4'h0);
        BusAck = 1'b1; BusRData = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("late_ack_req",   BusReq,    1'b0);
            check("late_ack_rdata", ReadDataM, model_rd);
        end
        BusAck = 1'b0;
        do_access("post_rst", 1, 0, 0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0);

`ifdef MEM_TIMEOUT_EN
        do_access("ackwin",  1, 0, 0, 32'h0000_0020, 32'h0, 32'h7777_1111, TIMEOUT - 1);
        do_access("tmo",     1, 0, 0, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 1000);
        do_access("tmo_st",  0, 1, 0, 32'h0000_0028, 32'h0000_00AA, 32'h0, 1000);
`else
        // With no watchdog an unanswered load stalls indefinitely.
        MemReadM = 1'b1; ByteM = 1'b0; ALUOutM = 32'h24;
        #1;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (StallM) hi++;
            tick();
        end
        check("noack_stall_cycles", 32'(hi), 32'd100);
        check("noack_req", BusReq,  1'b1);
        check("noack_err", MemErrM, 1'b0);
        RST = 1'b1;
        MemReadM = 1'b0;
        tick();
        RST = 1'b0;
        model_rd = '0;
        check("noack_rst_req", BusReq, 1'b0);
`endif
        do_access("final", 1, 0, 1, 32'h0000_0012, 32'h0, 32'h00EE_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
